// File: rtl/unibus_dma_master.sv
// unibus_dma_master: Unibus NPR master running one DATI/DATO/DATOB cycle per request.
// Define UNIDMA_HOLDBUS_EN to let req_hold keep BBSY between requests (HELD state).
module unibus_dma_master #(
  parameter int ADDR_SETUP  = 15,
  parameter int DATA_DESKEW = 8,
  parameter int ADDR_HOLD   = 8,
  parameter int TIMEOUT     = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        req_start,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_hold,
  input  logic [17:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_busy,
  output logic        req_done,
  output logic        req_timeout,
  output logic [15:0] req_rdata,
  output logic        npr_out_h,
  input  logic        npg_in_h,
  output logic        npg_out_h,
  output logic        sack_out_h,
  output logic        bbsy_out_h,
  output logic        msyn_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  input  logic        bbsy_in_h,
  input  logic        sack_in_h,
  input  logic        ssyn_in_h,
  input  logic        init_in_h,
  input  logic [15:0] d_in_h
);
  typedef enum logic [3:0] {IDLE, REQ, GRANT, SETUP, MSYN, DESKEW, UNMSYN, HOLD, RELEASE, HELD} state_t;
  // Terminal counts: a state lasts N cycles, or one cycle when N is 0.
  localparam logic [15:0] T_SETUP  = 16'(ADDR_SETUP  == 0 ? 0 : ADDR_SETUP  - 1);
  localparam logic [15:0] T_DESKEW = 16'(DATA_DESKEW == 0 ? 0 : DATA_DESKEW - 1);
  localparam logic [15:0] T_HOLD   = 16'(ADDR_HOLD   == 0 ? 0 : ADDR_HOLD   - 1);
  localparam logic [15:0] T_TMO    = 16'(TIMEOUT     == 0 ? 0 : TIMEOUT     - 1);
  state_t state, nxt;
  logic [15:0] cnt, wdata;
  logic [17:0] addr;
  logic wr, byt, tmo, abrt, accept, set_tmo, ld_rdata, abort, keep, bus_on;
  logic unused_in;
  assign unused_in = sack_in_h;
`ifdef UNIDMA_HOLDBUS_EN
  assign keep = req_hold & ~abrt & ~init_in_h;
`else
  logic unused_hold;
  assign unused_hold = req_hold;
  assign keep = 1'b0;
`endif
  assign abort = init_in_h && state inside {REQ, GRANT, SETUP, MSYN, DESKEW, UNMSYN, HOLD};
  always_comb begin
    nxt = state;
    accept = 1'b0;
    set_tmo = 1'b0;
    ld_rdata = 1'b0;
    case (state)
      IDLE: if (req_start && !init_in_h) begin accept = 1'b1; nxt = REQ; end
      REQ: if (npg_in_h) nxt = GRANT;
      GRANT: if (!bbsy_in_h && !ssyn_in_h && !npg_in_h) nxt = SETUP;
      SETUP: if (cnt == T_SETUP) nxt = MSYN;
      MSYN: if (ssyn_in_h) nxt = DESKEW;
            else if (cnt == T_TMO) begin nxt = UNMSYN; set_tmo = 1'b1; end
      DESKEW: if (cnt == T_DESKEW) begin nxt = UNMSYN; ld_rdata = ~wr; end
      UNMSYN: if (!ssyn_in_h) nxt = HOLD;
              else if (cnt == T_TMO) begin nxt = HOLD; set_tmo = 1'b1; end
      HOLD: if (cnt == T_HOLD) nxt = RELEASE;
      RELEASE: nxt = keep ? HELD : IDLE;
`ifdef UNIDMA_HOLDBUS_EN
      HELD: if (init_in_h) nxt = IDLE;
            else if (req_start) begin accept = 1'b1; nxt = SETUP; end
            else if (!req_hold) nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
    if (abort) begin
      nxt = RELEASE;
      set_tmo = 1'b1;
      ld_rdata = 1'b0;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      wr <= 1'b0;
      byt <= 1'b0;
      tmo <= 1'b0;
      abrt <= 1'b0;
      req_rdata <= '0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : (&cnt ? cnt : cnt + 16'd1);
      if (accept) begin
        addr <= req_addr;
        wdata <= req_wdata;
        wr <= req_write;
        byt <= req_byte;
        tmo <= 1'b0;
        abrt <= 1'b0;
      end
      if (set_tmo) tmo <= 1'b1;
      if (abort) abrt <= 1'b1;
      if (ld_rdata) req_rdata <= d_in_h;
    end
  end
  assign bus_on      = state inside {SETUP, MSYN, DESKEW, UNMSYN, HOLD};
  assign req_busy    = state inside {REQ, GRANT, SETUP, MSYN, DESKEW, UNMSYN, HOLD};
  assign req_done    = state == RELEASE;
  assign req_timeout = req_done & tmo;
  assign npr_out_h   = state == REQ;
  assign npg_out_h   = npg_in_h & (state == IDLE || state == HELD);
  assign sack_out_h  = state == GRANT;
  assign bbsy_out_h  = bus_on | (state == HELD);
  assign msyn_out_h  = state inside {MSYN, DESKEW};
  assign a_out_h     = bus_on ? addr : '0;
  assign c_out_h     = bus_on ? {wr, wr & byt} : 2'b00;
  assign d_out_h     = (bus_on && wr) ? wdata : '0;
endmodule
